hamming_byte_encoder: RTL
=========================

HAMMING_BYTE_ENCODER -- requirements
Module: hamming_byte_encoder

Interface
REQ-001 Parameter: CNT_W, default 16, width of the encoded-byte counter.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream byte valid.
REQ-005 Port: in_data  input  8  byte to encode; [3:0] low nibble, [7:4] high nibble.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: inj_en  input  1  inject a single-bit error into this byte's low codeword; sampled with the byte.
REQ-008 Port: inj_pos  input  3  codeword bit to flip, 0-6; value 7 means no flip; sampled with the byte.
REQ-009 Port: out_valid  output  1  out_code valid.
REQ-010 Port: out_code  output  7  Hamming(7,4) codeword for the downstream decoder.
REQ-011 Port: out_ready  input  1  downstream accepts out_code this cycle.
REQ-012 Port: out_hi  output  1  1 when out_code carries the high nibble (second codeword of a byte).
REQ-013 Port: byte_count  output  CNT_W  count of bytes whose both codewords have been accepted downstream.
REQ-014 Port: inj_count  output  8  count of codewords emitted with an injected error.

Function
REQ-015 Codeword layout for nibble d[3:0] SHALL be: bit0=p1, bit1=p2, bit2=d0, bit3=p4, bit4=d1, bit5=d2, bit6=d3.
REQ-016 Parity SHALL be: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3 (even parity).
REQ-017 FSM states SHALL be IDLE, LO, HI; out_valid=1 in LO and HI, 0 in IDLE.
REQ-018 in_ready SHALL be 1 in IDLE, (out_ready) in HI, 0 in LO; a byte is accepted on a cycle with in_valid&&in_ready.
REQ-019 IDLE + accept -> LO; IDLE without accept stays IDLE.
REQ-020 LO + out_ready -> HI; LO without out_ready holds state and out_code unchanged.
REQ-021 HI + out_ready + accept -> LO (back-to-back, no bubble); HI + out_ready without accept -> IDLE; HI without out_ready holds.
REQ-022 On accept, low and high codewords SHALL be computed and registered; out_code in LO is the low codeword, in HI the high codeword.
REQ-023 Latency: byte accepted on edge N -> low codeword valid in cycle N+1; high codeword valid the cycle after the low codeword is taken.
REQ-024 Sustained throughput with out_ready=1 and in_valid=1: one byte per 2 cycles.
REQ-025 If inj_en=1 and inj_pos<=6 at accept, bit inj_pos of the low codeword only SHALL be inverted; high codeword is never corrupted.
REQ-026 inj_count SHALL increment by 1 when a corrupted low codeword is taken (LO && out_ready), saturating at 255.
REQ-027 byte_count SHALL increment by 1 when HI && out_ready, wrapping from 2^CNT_W-1 to 0.
REQ-028 out_hi SHALL be 1 exactly in HI, 0 otherwise.
REQ-029 in_data/inj_en/inj_pos SHALL be ignored on cycles without accept.
REQ-030 out_code SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-031 When rst_n=0 at a rising edge: state=IDLE, out_code=0, out_valid=0, out_hi=0, byte_count=0, inj_count=0, stored injection cleared.
REQ-032 in_ready SHALL be 0 while rst_n=0; no byte accepted during reset.
REQ-033 Reset asserted mid-byte (LO or HI) SHALL discard the byte without incrementing byte_count.

Verification
REQ-034 Byte 0xA5, no inject, out_ready=1 -> out_code 0x2D (out_hi=0) then 0x52 (out_hi=1); byte_count=1.
REQ-035 Bytes 0x00 then 0xFF back-to-back, out_ready=1 -> codes 0x00,0x00,0x7F,0x7F on 4 consecutive cycles, no bubble; byte_count=2.
REQ-036 Byte 0xA5 with inj_en=1, inj_pos=2 -> 0x29 then 0x52; inj_count=1; with inj_pos=7 -> 0x2D, inj_count unchanged.
REQ-037 Byte 0xA5, out_ready=0 for 5 cycles in LO -> out_code held 0x2D, in_ready=0, no state change; release -> 0x52 next.
REQ-038 rst_n=0 while in HI -> next cycle out_valid=0, byte_count=0, in_ready=0 until rst_n=1.
REQ-039 Encoder output fed to the downstream Hamming decoder for all 256 bytes, each inj_pos 0-7 -> decoded nibbles equal input.

Source files
------------

// File: rtl/hamming_byte_encoder_if.sv
// Byte-in / codeword-out handshake bundle for hamming_byte_encoder.
//   in_valid, in_data[7:0], in_ready   : upstream byte handshake
//   inj_en, inj_pos[2:0]               : error-injection controls, sampled with the byte
//   out_valid, out_code[6:0], out_ready: downstream codeword handshake
//   out_hi                             : out_code carries the high nibble
// slave is the encoder's view; master is the view of whatever drives it.
interface hamming_byte_encoder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       inj_en;
    logic [2:0] inj_pos;
    logic       out_valid;
    logic [6:0] out_code;
    logic       out_ready;
    logic       out_hi;

    modport slave (
        input  in_valid, in_data, inj_en, inj_pos, out_ready,
        output in_ready, out_valid, out_code, out_hi
    );

    modport master (
        output in_valid, in_data, inj_en, inj_pos, out_ready,
        input  in_ready, out_valid, out_code, out_hi
    );
endinterface

// File: rtl/hamming_byte_encoder.sv
// Hamming(7,4) byte encoder: each accepted byte leaves as two codewords,
// low nibble first, then high nibble. An optional single-bit flip can be
// planted in the low codeword to exercise a downstream decoder.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : handshake bundle (slave view)
//   byte_count : bytes whose both codewords were taken downstream (wraps)
//   inj_count  : corrupted codewords taken downstream (saturates at 255)
module hamming_byte_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hamming_byte_encoder_if.slave   bus,
    output logic [CNT_W-1:0]        byte_count,
    output logic [7:0]              inj_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t     state;
    logic [6:0] code_hi;
    logic       lo_inj;

    logic       accept;
    logic [6:0] inj_mask;
    logic [6:0] enc_lo;
    logic [6:0] enc_hi;

    // Layout {d3,d2,d1,p4,d0,p2,p1}, even parity.
    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3], d[2], d[1],
                d[1] ^ d[2] ^ d[3],
                d[0],
                d[0] ^ d[2] ^ d[3],
                d[0] ^ d[1] ^ d[3]};
    endfunction

    // Upstream may hand over the next byte while the high codeword is taken.
    assign bus.in_ready = rst_n && ((state == IDLE) || ((state == HI) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // Position 7 is the "no flip" code.
    assign inj_mask = (bus.inj_en && (bus.inj_pos != 3'd7)) ? 7'(7'd1 << bus.inj_pos) : 7'd0;
    assign enc_lo   = encode(bus.in_data[3:0]) ^ inj_mask;
    assign enc_hi   = encode(bus.in_data[7:4]);

    // Control FSM with registered outputs and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.out_code  <= 7'd0;
            bus.out_valid <= 1'b0;
            bus.out_hi    <= 1'b0;
            code_hi       <= 7'd0;
            lo_inj        <= 1'b0;
            byte_count    <= '0;
            inj_count     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= LO;
                        bus.out_code  <= enc_lo;
                        bus.out_valid <= 1'b1;
                        bus.out_hi    <= 1'b0;
                        code_hi       <= enc_hi;
                        lo_inj        <= |inj_mask;
                    end
                end
                LO: begin
                    if (bus.out_ready) begin
                        state        <= HI;
                        bus.out_code <= code_hi;
                        bus.out_hi   <= 1'b1;
                        lo_inj       <= 1'b0;
                        if (lo_inj && (inj_count != 8'hFF)) begin
                            inj_count <= inj_count + 8'd1;
                        end
                    end
                end
                HI: begin
                    if (bus.out_ready) begin
                        byte_count <= byte_count + CNT_W'(1);
                        if (accept) begin
                            state        <= LO;
                            bus.out_code <= enc_lo;
                            bus.out_hi   <= 1'b0;
                            code_hi      <= enc_hi;
                            lo_inj       <= |inj_mask;
                        end else begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                            bus.out_hi    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.out_hi    <= 1'b0;
                end
            endcase
        end
    end

endmodule
